// File: rtl/karatsuba_2way_sequencer.sv
// Two-way Karatsuba sequencer for carry-less (GF(2)[x]) multiplication.
// Runs one shared HALF x HALF core three times (hi*hi, lo*lo, mid*mid),
// then XOR-combines the sub-products into the full 2*WIDTH product.
module karatsuba_2way_sequencer #(
    parameter int WIDTH = 224,
    localparam int HALF = WIDTH / 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    output logic                 sub_start,
    output logic [HALF-1:0]      sub_a,
    output logic [HALF-1:0]      sub_b,
    input  logic                 sub_done,
    input  logic [2*HALF-1:0]    sub_p,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_c,
    output logic                 busy,
    output logic                 err_spur
);

    typedef enum logic [2:0] {
        IDLE,
        HH,
        LL,
        MID,
        COMB,
        OUT
    } state_t;

    state_t              state;
    logic [WIDTH-1:0]    a_reg;
    logic [WIDTH-1:0]    b_reg;
    logic [2*HALF-1:0]   p_hh;
    logic [2*HALF-1:0]   p_ll;
    logic [2*HALF-1:0]   p_mid;
    logic [2*HALF-1:0]   p_cross;
    logic                done_ok;
    logic                done_spur;

    // Middle Karatsuba term and qualification of the core's done pulse.
    // A done in the same cycle as sub_start cannot belong to that start.
    always_comb begin
        p_cross   = p_mid ^ p_hh ^ p_ll;
        done_ok   = sub_done && !sub_start;
        done_spur = sub_done && (sub_start || state == IDLE ||
                                 state == COMB || state == OUT);
    end

    // Control FSM with registered handshake, core operand and product outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            sub_start <= 1'b0;
            sub_a     <= '0;
            sub_b     <= '0;
            out_valid <= 1'b0;
            out_c     <= '0;
            busy      <= 1'b0;
            err_spur  <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            p_hh      <= '0;
            p_ll      <= '0;
            p_mid     <= '0;
        end else begin
            sub_start <= 1'b0;
            if (done_spur) begin
                err_spur <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg     <= in_a;
                        b_reg     <= in_b;
                        sub_a     <= in_a[WIDTH-1:HALF];
                        sub_b     <= in_b[WIDTH-1:HALF];
                        sub_start <= 1'b1;
                        in_ready  <= 1'b0;
                        busy      <= 1'b1;
                        state     <= HH;
                    end
                end
                HH: begin
                    if (done_ok) begin
                        p_hh      <= sub_p;
                        sub_a     <= a_reg[HALF-1:0];
                        sub_b     <= b_reg[HALF-1:0];
                        sub_start <= 1'b1;
                        state     <= LL;
                    end
                end
                LL: begin
                    if (done_ok) begin
                        p_ll      <= sub_p;
                        sub_a     <= a_reg[WIDTH-1:HALF] ^ a_reg[HALF-1:0];
                        sub_b     <= b_reg[WIDTH-1:HALF] ^ b_reg[HALF-1:0];
                        sub_start <= 1'b1;
                        state     <= MID;
                    end
                end
                MID: begin
                    if (done_ok) begin
                        p_mid <= sub_p;
                        state <= COMB;
                    end
                end
                COMB: begin
                    out_c     <= {p_hh, {WIDTH{1'b0}}}
                               ^ {{HALF{1'b0}}, p_cross, {HALF{1'b0}}}
                               ^ {{WIDTH{1'b0}}, p_ll};
                    out_valid <= 1'b1;
                    state     <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
